// File: rtl/constraint_eval_arbiter.sv
// Round-robin arbiter sharing one registered shift-invert-reduce constraint check
// between NREQ requesters, with a tagged valid/ready response and saturating statistics.
module constraint_eval_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 18,
    parameter int IDW   = 2,
    parameter int CNTW  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4:0]            cfg_shift,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic                  resp_sat,
    output logic                  busy,
    output logic [CNTW-1:0]       sat_cnt,
    output logic [CNTW-1:0]       unsat_cnt,
    input  logic                  clr_cnt
);

    localparam int NSLOT = 1 << IDW;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        RESP
    } state_t;

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   g_q;
    logic [WIDTH-1:0] op_q;
    logic [4:0]       shamt_q;

    logic [NSLOT-1:0] valid_ext;
    logic [NSLOT-1:0] ready_ext;
    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic [IDW:0]     scan_idx;
    logic [WIDTH-1:0] op_sel;
    logic [WIDTH-1:0] shifted;

    assign valid_ext = NSLOT'(req_valid);

    // Scan from rr_ptr upward, wrapping at NREQ; first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (scan_idx >= (IDW+1)'(NREQ))
                scan_idx = scan_idx - (IDW+1)'(NREQ);
            if (!grant_found && valid_ext[scan_idx[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        op_sel = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (IDW'(k) == grant_idx)
                op_sel = req_data[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        ready_ext = '0;
        if (state == IDLE && grant_found)
            ready_ext[grant_idx] = 1'b1;
        req_ready = ready_ext[NREQ-1:0];
    end

    assign shifted = op_q >> shamt_q;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            g_q        <= '0;
            op_q       <= '0;
            shamt_q    <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_sat   <= 1'b0;
            sat_cnt    <= '0;
            unsat_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        op_q    <= op_sel;
                        g_q     <= grant_idx;
                        shamt_q <= cfg_shift;
                        state   <= EVAL;
                    end
                end
                EVAL: begin
                    resp_sat   <= |(~shifted);
                    resp_id    <= g_q;
                    rr_ptr     <= (g_q == IDW'(NREQ-1)) ? '0 : g_q + IDW'(1);
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Clear wins over an increment landing in the same cycle.
            if (clr_cnt) begin
                sat_cnt   <= '0;
                unsat_cnt <= '0;
            end else if (state == RESP && resp_ready) begin
                if (resp_sat) begin
                    if (sat_cnt != '1)
                        sat_cnt <= sat_cnt + CNTW'(1);
                end else begin
                    if (unsat_cnt != '1)
                        unsat_cnt <= unsat_cnt + CNTW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_constraint_eval_arbiter.sv
// Scoreboard bench for constraint_eval_arbiter: driver predicts grants and results from
// the arithmetic rules, a negedge monitor pops and compares responses and counters.
module tb_constraint_eval_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 18;
    localparam int IDW   = 2;
    localparam int CNTW  = 4;
    localparam int CMAX  = (1 << CNTW) - 1;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [4:0]            cfg_shift;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_data;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [IDW-1:0]        resp_id;
    logic                  resp_sat;
    logic                  busy;
    logic [CNTW-1:0]       sat_cnt;
    logic [CNTW-1:0]       unsat_cnt;
    logic                  clr_cnt;

    constraint_eval_arbiter #(
        .NREQ (NREQ),
        .WIDTH(WIDTH),
        .IDW  (IDW),
        .CNTW (CNTW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_shift (cfg_shift),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_id   (resp_id),
        .resp_sat  (resp_sat),
        .busy      (busy),
        .sat_cnt   (sat_cnt),
        .unsat_cnt (unsat_cnt),
        .clr_cnt   (clr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        bit sat;
    } exp_t;

    exp_t             sb[$];
    int               checks = 0;
    int               errors = 0;
    int               m_sat = 0;
    int               m_unsat = 0;
    int               rr = 0;
    logic [WIDTH-1:0] ops[NREQ];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Any shift of at least one zero-fills the MSB, so only an unshifted all-ones operand is unsat.
    function automatic bit model_sat(input logic [WIDTH-1:0] op, input int sh);
        return (sh >= 1) || (op != {WIDTH{1'b1}});
    endfunction

    task automatic pack_ops();
        for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = ops[i];
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++)
            ops[i] = ($urandom_range(0, 1) == 1) ? {WIDTH{1'b1}} : WIDTH'($urandom);
        pack_ops();
    endtask

    // Monitor: counters reflect all earlier edges; a handshake seen here lands on the next edge.
    exp_t mon_e;
    bit   mon_fire;
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            m_sat   = 0;
            m_unsat = 0;
            chk("cnt_in_reset", int'(sat_cnt) + int'(unsat_cnt), 0);
        end else begin
            chk("sat_cnt", int'(sat_cnt), m_sat);
            chk("unsat_cnt", int'(unsat_cnt), m_unsat);
            mon_fire = 1'b0;
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_resp", 1, 0);
                end else begin
                    chk("resp_id", int'(resp_id), sb[0].id);
                    chk("resp_sat", int'(resp_sat), int'(sb[0].sat));
                    if (resp_ready) begin
                        mon_e    = sb.pop_front();
                        mon_fire = 1'b1;
                    end
                end
            end
            if (clr_cnt) begin
                m_sat   = 0;
                m_unsat = 0;
            end else if (mon_fire) begin
                if (mon_e.sat) m_sat = (m_sat < CMAX) ? m_sat + 1 : CMAX;
                else m_unsat = (m_unsat < CMAX) ? m_unsat + 1 : CMAX;
            end
        end
    end

    // Called just after a rising edge with the DUT idle; returns just after a rising edge, idle again.
    task automatic xact(input logic [NREQ-1:0] mask, input int sh, input int hold, input bit clr_acc);
        int g = -1;
        req_valid = mask;
        cfg_shift = sh[4:0];
        pack_ops();
        for (int k = 0; k < NREQ; k++) begin
            int idx = (rr + k) % NREQ;
            if (g < 0 && mask[idx]) g = idx;
        end
        @(negedge clk);
        chk("busy_idle", int'(busy), 0);
        if (g < 0) begin
            chk("ready_none", int'(req_ready), 0);
            @(posedge clk); #1;
            return;
        end
        chk("req_ready_grant", int'(req_ready), 1 << g);
        sb.push_back('{g, model_sat(ops[g], sh)});
        rr = (g + 1) % NREQ;
        @(posedge clk); #1;
        req_valid = NREQ'($urandom);
        cfg_shift = 5'($urandom);
        rand_ops();
        @(negedge clk);
        chk("ready_eval", int'(req_ready), 0);
        chk("valid_eval", int'(resp_valid), 0);
        chk("busy_eval", int'(busy), 1);
        @(posedge clk); #1;
        req_valid  = NREQ'($urandom);
        resp_ready = (hold == 0);
        clr_cnt    = clr_acc && (hold == 0);
        @(negedge clk);
        chk("valid_latency", int'(resp_valid), 1);
        chk("ready_resp", int'(req_ready), 0);
        while (hold > 0) begin
            @(posedge clk); #1;
            hold--;
            req_valid = NREQ'($urandom);
            if (hold == 0) begin
                resp_ready = 1'b1;
                clr_cnt    = clr_acc;
            end
            @(negedge clk);
            chk("ready_bp", int'(req_ready), 0);
            chk("valid_bp", int'(resp_valid), 1);
        end
        @(posedge clk); #1;
        resp_ready = 1'b0;
        clr_cnt    = 1'b0;
        req_valid  = '0;
        chk("valid_drop", int'(resp_valid), 0);
        chk("busy_done", int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid  = '0;
        req_data   = '0;
        cfg_shift  = '0;
        resp_ready = 1'b0;
        clr_cnt    = 1'b0;
        for (int i = 0; i < NREQ; i++) ops[i] = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        chk("rst_resp_valid", int'(resp_valid), 0);
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_resp_id", int'(resp_id), 0);
        chk("rst_resp_sat", int'(resp_sat), 0);
        chk("rst_busy", int'(busy), 0);
        @(posedge clk); #1;

        ops[1] = 18'h3FFFF;
        xact(4'b0010, 0, 0, 0);
        chk("single_unsat_cnt", int'(unsat_cnt), 1);

        ops[0] = 18'h3FFFF; xact(4'b0001, 9, 0, 0);
        ops[0] = 18'h00000; xact(4'b0001, 0, 0, 0);
        ops[0] = 18'h3FFFF; xact(4'b0001, 20, 0, 0);
        ops[0] = 18'h3FFFF; xact(4'b0001, 1, 0, 0);
        ops[0] = 18'h3FFFF; xact(4'b0001, 31, 0, 0);

        for (int n = 0; n < 12; n++) begin
            rand_ops();
            xact(4'b1111, $urandom_range(0, 2), 0, 0);
        end

        rand_ops();
        xact(4'b0100, 0, 5, 0);

        clr_cnt = 1'b1;
        @(posedge clk); #1;
        clr_cnt = 1'b0;
        for (int n = 0; n < 17; n++) begin
            rand_ops();
            xact(4'b1111, $urandom_range(1, 31), 0, 0);
        end
        chk("sat_saturated", int'(sat_cnt), CMAX);
        rand_ops();
        xact(4'b1111, 0, 0, 1);
        chk("clr_sat", int'(sat_cnt), 0);
        chk("clr_unsat", int'(unsat_cnt), 0);

        for (int n = 0; n < 150; n++) begin
            int sh;
            int hold;
            rand_ops();
            sh   = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(0, 31);
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            xact(NREQ'($urandom), sh, hold, $urandom_range(0, 15) == 0);
        end

        // Reset in the middle of a response: the pending result must vanish and rr_ptr return to 0.
        rand_ops();
        ops[1]    = 18'h3FFFF;
        pack_ops();
        req_valid = 4'b0010;
        cfg_shift = '0;
        sb.push_back('{1, 1'b0});
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_valid", int'(resp_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", int'(resp_valid), 0);
        chk("async_rst_busy", int'(busy), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rr = 0;
        chk("post_rst_valid", int'(resp_valid), 0);
        rand_ops();
        xact(4'b1111, 0, 0, 0);
        rand_ops();
        xact(4'b1110, 3, 1, 0);

        @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/constraint_eval_arbiter.md
Name: constraint_eval_arbiter

Overview:
Shares one registered instance of the shift-invert-reduce constraint check, sat = |(~(operand >> shamt)), between NREQ requesters. Requesters present 18-bit operands over valid/ready; the block grants round-robin, evaluates, and returns a tagged result over a single valid/ready response channel. Saturating sat/unsat counters feed solver statistics.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 18, operand width
IDW, 2, response id width (>= clog2(NREQ))
CNTW, 16, statistics counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cfg_shift  in  5  shift amount; sampled at grant
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept (one-hot or zero)
req_data  in  NREQ*WIDTH  operands; requester i at [i*WIDTH +: WIDTH]
resp_valid  out  1  result valid
resp_ready  in  1  downstream accept
resp_id  out  IDW  index of the granted requester
resp_sat  out  1  constraint result
busy  out  1  high in any state other than IDLE
sat_cnt  out  CNTW  saturating count of sat=1 responses
unsat_cnt  out  CNTW  saturating count of sat=0 responses
clr_cnt  in  1  synchronous clear of both counters

Behaviour:
- Reset (async assert, sync release): state IDLE, rr_ptr=0, req_ready=0, resp_valid=0, resp_id=0, resp_sat=0, busy=0, sat_cnt=0, unsat_cnt=0.
- FSM IDLE -> EVAL -> RESP -> IDLE.
- IDLE: if any req_valid, choose the first valid index at or after rr_ptr, wrapping modulo NREQ. Assert req_ready[g] combinationally in the same cycle; the handshake fires there. Latch operand, g and cfg_shift; go to EVAL. req_ready is 0 in every other state.
- EVAL: one cycle. Compute sat = |(~(op >> shamt)) as a logical shift at WIDTH bits. Register resp_sat and resp_id=g; set rr_ptr=(g+1) mod NREQ; go to RESP.
- Arithmetic consequence: shamt>=1 always yields sat=1 (zero-filled MSBs invert to 1). shamt=0 gives sat=0 only when op is all ones. shamt>=WIDTH yields sat=1.
- RESP: resp_valid=1; resp_id and resp_sat stay stable until resp_ready. When resp_ready is high: increment sat_cnt or unsat_cnt (saturate at all-ones, no wrap); go to IDLE.
- Throughput: one result every 3 cycles at most, with zero resp back-pressure. Request-to-resp_valid latency is 2 cycles.
- resp_valid must never drop without resp_ready. Requesters may drop req_valid while not granted; no grant is remembered.
- clr_cnt has priority over a same-cycle increment; both counters read 0 next cycle.
- cfg_shift changes after grant do not affect the in-flight evaluation.
- Reset mid-operation: the in-flight request is lost and nothing is issued after reset. The requester must re-request.

Test Plan:
- Reset then idle: all outputs 0. Pulse rst_n low during RESP: resp_valid drops immediately (async) and rr_ptr=0.
- Single request: req_valid=4'b0010, data=18'h3FFFF, cfg_shift=0. Expect req_ready=4'b0010 in the same cycle, then 2 cycles later resp_valid=1, resp_id=1, resp_sat=0, unsat_cnt=1.
- Shift cases from requester 0: data=18'h3FFFF, shift=9 -> sat=1. data=18'h00000, shift=0 -> sat=1. data=18'h3FFFF, shift=20 -> sat=1.
- Fairness: all four req_valid held high for 12 responses. Expect grant order 0,1,2,3,0,1,2,3,... and no requester starved.
- Back-pressure: hold resp_ready=0 for 5 cycles. Expect resp_id/resp_sat stable, req_ready=0 throughout, exactly one counter increment on release.
- Counters: with CNTW=4, issue 17 sat responses -> sat_cnt=15. Assert clr_cnt in the same cycle as an accepted response -> both counters 0.
